dl_shifter_pipe: RTL and testbench
==================================

# dl_shifter_pipe

Parameterised, pipelined shift unit for the execute datapath: one operand per cycle through a valid/ready pipeline. Supports logical left, logical right, arithmetic right and rotate right, with the shift amount resolved in configurable slices across `NUM_STAGES` register stages. It sits between issue and writeback, and carries an opaque tag so results can be matched to their destination.

## Interface
- `NUM_BITS`, 32: operand width; power of two, ≥ 4.
- `NUM_STAGES`, 2: pipeline register stages, 1..`NUM_SHIFT_BITS`.
- `TAG_BITS`, 5: width of passthrough tag.
- `NUM_SHIFT_BITS` (localparam): `$clog2(NUM_BITS)`.

Ports:
- `clk`, input, 1: clock; all state on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `flush`, input, 1: synchronous kill of all in-flight ops.
- `in_valid`, input, 1: operand valid.
- `in_ready`, output, 1: unit can accept this cycle.
- `in_data`, input, `NUM_BITS`: operand.
- `in_shamt`, input, `NUM_SHIFT_BITS`: shift amount.
- `in_op`, input, 2: operation; 0 SLL, 1 SRL, 2 SRA, 3 ROR.
- `in_tag`, input, `TAG_BITS`: passthrough tag.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts.
- `out_data`, output, `NUM_BITS`: result.
- `out_tag`, output, `TAG_BITS`: tag of result.

## Operation
- Slice width `BPS = ceil(NUM_SHIFT_BITS / NUM_STAGES)`. Stage k applies shamt bits `[k*BPS, min((k+1)*BPS, NUM_SHIFT_BITS)-1]`, LSB slice first. A stage with an empty slice is a pure register.
- Each stage register holds: valid, data, residual shamt, op, tag and the sign bit (`in_data[NUM_BITS-1]`, captured at entry).
- SRA fills vacated MSBs with the captured sign bit, not the current partial MSB.
- SLL/SRL fill vacated bits with zero.
- ROR: bits shifted out at the LSB re-enter at the MSB.
- Shamt 0 passes data unchanged for every op.
- Handshake: elastic pipeline, no bubbles under backpressure.
  - Stage k advances when its successor is empty or advancing; the last stage advances when `out_ready`.
  - `in_ready = !v0 | adv0`. Transfers occur only when valid & ready are both high.
  - `out_*` is stable while `out_valid & !out_ready`.
- `flush`: all stage valids clear at the next edge. The input beat presented in the flush cycle is dropped even if `in_ready` was high. Data registers are not cleared.
- Reset: all valids 0, `out_data` 0, `out_tag` 0, `in_ready` 1 after reset release.
- Data/tag registers load only on advance, so there is no toggling when idle.

## Timing
- Latency: `NUM_STAGES` cycles from input handshake to `out_valid`.
  - `NUM_STAGES=1`: result visible the cycle after accept.
- Throughput: one op/cycle with `out_ready` held high.
- Capacity: `NUM_STAGES` ops. With `out_ready` low, `in_ready` falls once all stages are full.
- Simultaneous output pop and input push on a full pipe: both complete and occupancy is unchanged.
- `flush` and `rst` take priority over any advance in the same cycle.
- Combinational path from `out_ready` to `in_ready` through the advance chain is permitted.

## Structure
- Package `dl_shift_pkg`:
  - `shift_op_e` enum (`SHIFT_SLL`/`SHIFT_SRL`/`SHIFT_SRA`/`SHIFT_ROR` = 0..3).
  - Function computing the slice bounds for stage k.
- Sub-module `dl_shift_stage`:
  - One combinational slice shifter plus pipeline register.
  - Parameters: `NUM_BITS`, `LO`, `HI`, `TAG_BITS`.
  - Instantiated `NUM_STAGES` times via generate.
- Top level holds only the advance chain, flush and output wiring.

## Test plan
- SRA, `NUM_BITS=32`, `NUM_STAGES=2`, in `0x8000_00F0` shamt 4 → `0xF800_000F` two cycles after accept. Same with shamt 31 → `0xFFFF_FFFF`.
- SRL/SLL/ROR on `0x8000_0001` shamt 1 → `0x4000_0000` / `0x0000_0002` / `0xC000_0000`. Shamt 0 returns `0x8000_0001` for all ops.
- Backpressure:
  - Hold `out_ready=0` and stream 3 ops; 2 are accepted, then `in_ready=0`.
  - Release `out_ready`; results and tags 0,1,2 emerge in order on consecutive cycles, with no loss or duplication.
- Flush with 2 ops in flight plus `in_valid` in the same cycle → `out_valid` stays 0; the next op after the flush returns correctly with its tag.
- Assert `rst` asynchronously mid-stream → `out_valid=0` and `out_data=0` immediately; the pipe is empty after release.
- Random sweep over `NUM_STAGES` ∈ {1,3,5} (`NUM_BITS=32`) and `NUM_BITS=8`, checked against a reference model with random `out_ready` → exact match and ordering.

Source files
------------

// File: rtl/dl_shift_pkg.sv
// Shared types and elaboration helpers for the pipelined shift unit.
package dl_shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'd0,
    SHIFT_SRL = 2'd1,
    SHIFT_SRA = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_op_e;

  // Inclusive range of shift-amount bits resolved by one stage.
  // hi < lo marks an empty slice, and that stage is then a plain register.
  typedef struct packed {
    int lo;
    int hi;
  } slice_t;

  // Slices are ceil(nsb/nstages) bits wide, LSB slice in stage 0.
  function automatic slice_t slice_bounds(input int k, input int nsb, input int nstages);
    int     bps;
    int     top;
    slice_t s;
    bps  = (nsb + nstages - 1) / nstages;
    top  = ((k + 1) * bps < nsb) ? (k + 1) * bps : nsb;
    s.lo = k * bps;
    s.hi = top - 1;
    return s;
  endfunction

endpackage

// File: rtl/dl_shift_stage.sv
// One pipeline stage: shifts by the shamt bits [LO..HI] it owns, then registers
// the partial result together with its control fields.
module dl_shift_stage
  import dl_shift_pkg::*;
#(
  parameter  int NUM_BITS = 32,
  parameter  int LO       = 0,
  parameter  int HI       = 0,
  parameter  int TAG_BITS = 5,
  localparam int NSB      = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_flush,
  input  logic                i_ready,
  input  logic                i_valid,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic [NSB-1:0]      i_shamt,
  input  shift_op_e           i_op,
  input  logic [TAG_BITS-1:0] i_tag,
  input  logic                i_sign,
  output logic                o_valid,
  output logic [NUM_BITS-1:0] o_data,
  output logic [NSB-1:0]      o_shamt,
  output shift_op_e           o_op,
  output logic [TAG_BITS-1:0] o_tag,
  output logic                o_sign
);

  // Bits of the shift amount owned by this stage; all-zero for an empty slice,
  // which turns the shifter below into a wire.
  function automatic logic [NSB-1:0] slice_mask();
    logic [NSB-1:0] m;
    m = '0;
    for (int i = 0; i < NSB; i++) begin
      if (i >= LO && i <= HI) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [NSB-1:0] SLICE_MASK = slice_mask();

  logic [NSB-1:0]      w_amt;
  logic [NUM_BITS-1:0] w_result;

  assign w_amt = i_shamt & SLICE_MASK;

  // Partial shift by this stage's slice; SRA fills from the sign captured at entry.
  always_comb begin
    // NOTE: default first so every path assigns w_result and no latch is inferred.
    w_result = i_data;
    case (i_op)
      SHIFT_SLL: w_result = i_data << w_amt;
      SHIFT_SRL: w_result = i_data >> w_amt;
      SHIFT_SRA: w_result = NUM_BITS'({{NUM_BITS{i_sign}}, i_data} >> w_amt);
      SHIFT_ROR: w_result = NUM_BITS'({i_data, i_data} >> w_amt);
      default:   w_result = i_data;
    endcase
  end

  // Stage register: valid follows the enable, payload loads only on a real transfer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every stage samples pre-edge values.
    if (rst) begin
      // NOTE: payload is reset too, so the unit presents zero data/tag out of reset.
      o_valid <= 1'b0;
      o_data  <= '0;
      o_shamt <= '0;
      o_op    <= SHIFT_SLL;
      o_tag   <= '0;
      o_sign  <= 1'b0;
    end else begin
      if (i_flush)      o_valid <= 1'b0;
      else if (i_ready) o_valid <= i_valid;

      if (!i_flush && i_ready && i_valid) begin
        o_data  <= w_result;
        o_shamt <= i_shamt;
        o_op    <= i_op;
        o_tag   <= i_tag;
        o_sign  <= i_sign;
      end
    end
  end

endmodule

// File: rtl/dl_shifter_pipe.sv
// Elastic multi-stage shift unit (SLL/SRL/SRA/ROR) with tag passthrough.
// This level only builds the ready chain and chains the stages together.
module dl_shifter_pipe
  import dl_shift_pkg::*;
#(
  parameter  int NUM_BITS       = 32,
  parameter  int NUM_STAGES     = 2,
  parameter  int TAG_BITS       = 5,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BITS-1:0]       in_data,
  input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
  input  logic [1:0]                in_op,
  input  logic [TAG_BITS-1:0]       in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out_data,
  output logic [TAG_BITS-1:0]       out_tag
);

  // Index 0 is the unit input; index k+1 is the register output of stage k.
  logic [NUM_STAGES:0]       w_valid;
  logic [NUM_STAGES:0]       w_sign;
  logic [NUM_BITS-1:0]       w_data  [NUM_STAGES+1];
  logic [NUM_SHIFT_BITS-1:0] w_shamt [NUM_STAGES+1];
  shift_op_e                 w_op    [NUM_STAGES+1];
  logic [TAG_BITS-1:0]       w_tag   [NUM_STAGES+1];
  logic [NUM_STAGES-1:0]     w_ready;
  logic                      w_unused_tail;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_shamt[0] = in_shamt;
  assign w_op[0]    = shift_op_e'(in_op);
  assign w_tag[0]   = in_tag;
  assign w_sign[0]  = in_data[NUM_BITS-1];

  // Ready chain from the output back: a stage can take a beat when it is empty
  // or its occupant moves on this cycle (successor ready, or out_ready at the end).
  always_comb begin
    logic carry;
    carry   = out_ready;
    w_ready = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !w_valid[k+1] || carry;
      carry      = w_ready[k];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam slice_t SLICE = slice_bounds(k, NUM_SHIFT_BITS, NUM_STAGES);

    dl_shift_stage #(
      .NUM_BITS (NUM_BITS),
      .LO       (SLICE.lo),
      .HI       (SLICE.hi),
      .TAG_BITS (TAG_BITS)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_ready (w_ready[k]),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_shamt (w_shamt[k]),
      .i_op    (w_op[k]),
      .i_tag   (w_tag[k]),
      .i_sign  (w_sign[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_shamt (w_shamt[k+1]),
      .o_op    (w_op[k+1]),
      .o_tag   (w_tag[k+1]),
      .o_sign  (w_sign[k+1])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[NUM_STAGES];
  assign out_data  = w_data[NUM_STAGES];
  assign out_tag   = w_tag[NUM_STAGES];

  // Control fields of the last stage have no consumer.
  assign w_unused_tail = ^{w_shamt[NUM_STAGES], w_op[NUM_STAGES], w_sign[NUM_STAGES]};

endmodule

// File: tb/tb_dl_shifter_pipe.sv
// Bench for dl_shifter_pipe: directed checks on the default 32-bit/2-stage unit,
// then a random sweep of 1/3/5-stage 32-bit and 2-stage 8-bit units against a
// queue-based reference.
module tb_dl_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Directed unit (defaults: 32 bits, 2 stages)
  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [31:0] d_in_data, d_out_data;
  logic [4:0]  d_in_shamt, d_in_tag, d_out_tag;
  logic [1:0]  d_in_op;

  dl_shifter_pipe #(.NUM_BITS(32), .NUM_STAGES(2), .TAG_BITS(5)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (d_flush),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_data   (d_in_data),
    .in_shamt  (d_in_shamt),
    .in_op     (d_in_op),
    .in_tag    (d_in_tag),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_data  (d_out_data),
    .out_tag   (d_out_tag)
  );

  // Sweep units share input stimulus; each has its own out_ready.
  function automatic int sw_bits(input int g);
    return (g == 3) ? 8 : 32;
  endfunction

  function automatic int sw_stages(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 5 : 2;
  endfunction

  logic        s_in_valid;
  logic [31:0] s_in_data;
  logic [4:0]  s_in_shamt, s_in_tag;
  logic [1:0]  s_in_op;
  logic [3:0]  s_out_ready, s_in_ready, s_out_valid;
  logic [31:0] s_out_data [4];
  logic [4:0]  s_out_tag  [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int NB = sw_bits(g);
    localparam int NS = sw_stages(g);
    localparam int SB = $clog2(NB);
    logic [NB-1:0] od;

    dl_shifter_pipe #(.NUM_BITS(NB), .NUM_STAGES(NS), .TAG_BITS(5)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready[g]),
      .in_data   (s_in_data[NB-1:0]),
      .in_shamt  (s_in_shamt[SB-1:0]),
      .in_op     (s_in_op),
      .in_tag    (s_in_tag),
      .out_valid (s_out_valid[g]),
      .out_ready (s_out_ready[g]),
      .out_data  (od),
      .out_tag   (s_out_tag[g])
    );

    assign s_out_data[g] = 32'(od);
  end

  // Reference shift, straight from the operation definitions on an nb-bit word.
  function automatic logic [31:0] ref_shift(input int nb, input logic [31:0] d,
                                            input int s, input logic [1:0] op);
    logic [63:0] mask, x, r;
    mask = (64'd1 << nb) - 64'd1;
    x    = {32'd0, d} & mask;
    case (op)
      2'd0: r = (x << s) & mask;
      2'd1: r = x >> s;
      2'd2: begin
        r = x >> s;
        if (x[nb-1]) r = r | (mask & ~(mask >> s));
      end
      default: r = ((x >> s) | (x << (nb - s))) & mask;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op through the idle directed unit with out_ready high: checks accept,
  // exact two-cycle latency, result, tag, then that the unit drains.
  task automatic send_check(input string name, input logic [31:0] data, input logic [4:0] shamt,
                            input logic [1:0] op, input logic [4:0] tag, input logic [31:0] exp);
    d_in_valid = 1'b1;
    d_in_data  = data;
    d_in_shamt = shamt;
    d_in_op    = op;
    d_in_tag   = tag;
    #1;
    check({name, ".in_ready"}, d_in_ready, 1);
    tick();
    d_in_valid = 1'b0;
    check({name, ".early_valid"}, d_out_valid, 0);
    tick();
    check({name, ".out_valid"}, d_out_valid, 1);
    check({name, ".data"}, d_out_data, exp);
    check({name, ".tag"}, d_out_tag, tag);
    tick();
    check({name, ".drained"}, d_out_valid, 0);
  endtask

  logic [36:0] exp_q [4][$];

  // Sweep scoreboard step for unit g, evaluated just before the clock edge.
  task automatic sw_process(input int g);
    logic [36:0] e;
    int          nb;
    nb = sw_bits(g);
    if (s_out_valid[g] && s_out_ready[g]) begin
      check($sformatf("sw%0d.pop_expected", g), exp_q[g].size() != 0, 1);
      if (exp_q[g].size() != 0) begin
        e = exp_q[g].pop_front();
        check($sformatf("sw%0d.data", g), s_out_data[g], e[31:0]);
        check($sformatf("sw%0d.tag", g), s_out_tag[g], e[36:32]);
      end
    end
    if (s_in_valid && s_in_ready[g]) begin
      exp_q[g].push_back({s_in_tag,
                          ref_shift(nb, s_in_data, int'(s_in_shamt) & (nb - 1), s_in_op)});
    end
  endtask

  logic [31:0] bp_exp [3];

  initial begin
    rst         = 1'b1;
    d_flush     = 1'b0;
    d_in_valid  = 1'b0;
    d_in_data   = '0;
    d_in_shamt  = '0;
    d_in_op     = '0;
    d_in_tag    = '0;
    d_out_ready = 1'b1;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_in_shamt  = '0;
    s_in_op     = '0;
    s_in_tag    = '0;
    s_out_ready = '1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", d_out_valid, 0);
    check("rst.out_data", d_out_data, 0);
    rst = 1'b0;
    #1;
    check("rel.in_ready", d_in_ready, 1);
    check("rel.out_valid", d_out_valid, 0);
    check("rel.out_tag", d_out_tag, 0);
    tick();

    // Directed op results
    send_check("sra4",  32'h8000_00F0, 5'd4,  2'd2, 5'd1, 32'hF800_000F);
    send_check("sra31", 32'h8000_00F0, 5'd31, 2'd2, 5'd2, 32'hFFFF_FFFF);
    send_check("srl1",  32'h8000_0001, 5'd1,  2'd1, 5'd3, 32'h4000_0000);
    send_check("sll1",  32'h8000_0001, 5'd1,  2'd0, 5'd4, 32'h0000_0002);
    send_check("ror1",  32'h8000_0001, 5'd1,  2'd3, 5'd5, 32'hC000_0000);
    send_check("sll0",  32'h8000_0001, 5'd0,  2'd0, 5'd6, 32'h8000_0001);
    send_check("srl0",  32'h8000_0001, 5'd0,  2'd1, 5'd7, 32'h8000_0001);
    send_check("sra0",  32'h8000_0001, 5'd0,  2'd2, 5'd8, 32'h8000_0001);
    send_check("ror0",  32'h8000_0001, 5'd0,  2'd3, 5'd9, 32'h8000_0001);

    // Backpressure: fill the pipe, stall, then release with a simultaneous push
    d_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = 32'h9ABC_DEF1 + 32'(i);
      d_in_shamt = 5'(i + 3);
      d_in_op    = 2'(i);
      d_in_tag   = 5'(i);
      bp_exp[i]  = ref_shift(32, d_in_data, i + 3, d_in_op);
      #1;
      check($sformatf("bp.in_ready%0d", i), d_in_ready, (i < 2) ? 1 : 0);
      if (i < 2) tick();
    end
    tick();
    check("bp.stall_valid", d_out_valid, 1);
    check("bp.stall_tag", d_out_tag, 0);
    check("bp.stall_data", d_out_data, bp_exp[0]);
    check("bp.stall_in_ready", d_in_ready, 0);
    d_out_ready = 1'b1;
    #1;
    check("bp.pushpop_ready", d_in_ready, 1);
    tick();
    d_in_valid = 1'b0;
    for (int j = 1; j < 3; j++) begin
      check($sformatf("bp.valid%0d", j), d_out_valid, 1);
      check($sformatf("bp.tag%0d", j), d_out_tag, j);
      check($sformatf("bp.data%0d", j), d_out_data, bp_exp[j]);
      tick();
    end
    check("bp.empty", d_out_valid, 0);

    // Flush with two ops in flight and a third presented in the flush cycle
    d_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = 32'h1234_5678;
      d_in_shamt = 5'd8;
      d_in_op    = 2'd3;
      d_in_tag   = 5'(3 + i);
      tick();
    end
    d_in_tag = 5'd5;
    d_flush  = 1'b1;
    tick();
    d_flush     = 1'b0;
    d_in_valid  = 1'b0;
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flush.out_valid%0d", i), d_out_valid, 0);
      tick();
    end
    send_check("postflush", 32'h0000_F00D, 5'd12, 2'd0, 5'd9, 32'h0F00_D000);

    // Asynchronous reset mid-stream
    d_out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_in_valid = 1'b1;
      d_in_data  = 32'h0000_0001;
      d_in_shamt = 5'd4;
      d_in_op    = 2'd0;
      d_in_tag   = 5'(7 + i);
      tick();
    end
    d_in_valid = 1'b0;
    check("arst.pre_valid", d_out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.out_valid", d_out_valid, 0);
    check("arst.out_data", d_out_data, 0);
    check("arst.out_tag", d_out_tag, 0);
    check("arst.in_ready", d_in_ready, 1);
    #1;
    rst         = 1'b0;
    d_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("arst.empty%0d", i), d_out_valid, 0);
    end

    // Random sweep with random per-unit backpressure
    for (int c = 0; c < 800; c++) begin
      s_in_valid = ($urandom_range(0, 3) != 0);
      s_in_data  = $urandom;
      s_in_shamt = 5'($urandom);
      s_in_op    = 2'($urandom);
      s_in_tag   = 5'($urandom);
      for (int g = 0; g < 4; g++) s_out_ready[g] = ($urandom_range(0, 3) != 0);
      #1;
      for (int g = 0; g < 4; g++) sw_process(g);
      tick();
    end
    s_in_valid  = 1'b0;
    s_out_ready = '1;
    for (int c = 0; c < 20; c++) begin
      #1;
      for (int g = 0; g < 4; g++) sw_process(g);
      tick();
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sw%0d.leftover", g), exp_q[g].size(), 0);
      check($sformatf("sw%0d.idle_valid", g), s_out_valid[g], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
